regs_wb_sched: RTL and testbench
================================

# regs_wb_sched

Writeback scheduler for the LC-3 core register file. It shares the register file's single write port between the ALU result path and the memory-load return path. Load returns are buffered in a 2-entry FIFO. A per-register scoreboard tracks outstanding loads and raises a stall to the decode stage on read-after-write and write-after-write hazards. The block sits between execute/memory and the register file, and drives its `w_en_i_w` / `w_addr_i_w` / `w_dat_i_w` directly.

## Interface
- No parameters. The FIFO depth is fixed at 2 and each scoreboard counter is fixed at 2 bits.
- `clk_i_w` in 1: clock. All state changes on the rising edge.
- `rst_i_w` in 1: reset, asynchronous, active-low.
- `alu_vld_i_w` in 1: ALU result valid.
- `alu_addr_i_w` in 3: ALU destination register.
- `alu_dat_i_w` in 16: ALU result.
- `alu_rdy_o_w` out 1: ALU result accepted this cycle.
- `ld_iss_i_w` in 1: a load to `ld_iss_dst_i_w` issues this cycle.
- `ld_iss_dst_i_w` in 3: destination register of the issuing load.
- `ld_vld_i_w` in 1: load return data valid.
- `ld_addr_i_w` in 3: load destination register.
- `ld_dat_i_w` in 16: load data.
- `ld_rdy_o_w` out 1: load return accepted this cycle.
- `chk_vld_i_w` in 1: decode is presenting an instruction for hazard check.
- `chk_src1_i_w` in 3, `chk_src2_i_w` in 3, `chk_dst_i_w` in 3: registers to check.
- `stall_o_w` out 1: hazard, so decode must hold.
- `w_en_o_r` out 1: register-file write enable (registered).
- `w_addr_o_r` out 3: register-file write address (registered).
- `w_dat_o_r` out 16: register-file write data (registered).

## Operation
- **Load FIFO.** 2 entries of {addr, data}, plus a 2-bit count in the range 0..2.
  - Push when `ld_vld_i_w && ld_rdy_o_w`.
  - `ld_rdy_o_w = (count != 2)`. There is no bypass of a full FIFO, even when it pops in the same cycle.
  - Push and pop in the same cycle: count is unchanged and the pushed entry goes behind the head.
- **Write-port grant.** Evaluated every cycle, in this priority order:
  1. FIFO full (count == 2): grant the FIFO head.
  2. Else `alu_vld_i_w`: grant the ALU.
  3. Else FIFO non-empty: grant the FIFO head.
  4. Else no grant.
- `alu_rdy_o_w = alu_vld_i_w && (count != 2)`. An ALU result is accepted only when granted, and upstream holds it otherwise.
- **Output register update.**
  - On a grant: `w_en_o_r <= 1` and `w_addr_o_r` / `w_dat_o_r` take the granted source.
  - With no grant: `w_en_o_r <= 0`, and addr/data hold their previous values.
  - A FIFO pop happens exactly when the FIFO is granted.
- **Scoreboard.** `pend[r]` is a 2-bit counter for each of R0..R7.
  - Increments on `ld_iss_i_w` to `r`.
  - Decrements when a FIFO head with addr `r` is granted.
  - Both in the same cycle on the same `r`: unchanged.
  - Increment at 3 holds at 3. Decrement at 0 holds at 0. Both are upstream errors and must not wrap.
- **Stall.** `stall_o_w = chk_vld_i_w && (pend[src1] != 0 || pend[src2] != 0 || pend[dst] != 0)`. It is combinational and uses current state only.
- The ALU path never touches the scoreboard. Write-after-write ordering is guaranteed by the dst check: no ALU op targets a register with a pending load.

## Timing
- **Reset values (asynchronous, while `rst_i_w` is low):**
  - FIFO count 0, all `pend` 0.
  - `w_en_o_r` 0, `w_addr_o_r` 0, `w_dat_o_r` 0.
  - Consequently `alu_rdy_o_w` 0, `ld_rdy_o_w` 1, `stall_o_w` 0.
- **Reset mid-operation:** buffered loads and pending counts are discarded, and a write in flight on `w_en_o_r` is dropped.
- **ALU latency:** an ALU result accepted at edge N appears on `w_en_o_r` / `w_addr_o_r` / `w_dat_o_r` during cycle N+1. The register file commits it at edge N+1.
- **Load latency:**
  - Return pushed at edge N, FIFO empty, no ALU request: head is granted in cycle N+1 and `w_en_o_r` is high in cycle N+2.
  - The pending count drops at the grant edge, so the stall clears in the same cycle `w_en_o_r` is asserted. The register file's write-to-read forwarding supplies the value that cycle.
- **Starvation bound:** a load waits at most until the FIFO fills. Under continuous ALU traffic the FIFO drains one entry every cycle it is full.
- **Combinational outputs:** `alu_rdy_o_w`, `ld_rdy_o_w` and `stall_o_w` have no registered delay.

## Test plan
- **Reset:** assert `rst_i_w` low mid-stream with a FIFO count of 2 and `pend[3] = 2`. Required: all outputs at their reset values immediately, `ld_rdy_o_w = 1`, and `stall_o_w = 0` for `chk_src1 = 3`.
- **ALU path:** ALU writes R2 = 0x1234 at edge N. Required: in cycle N+1, `w_en_o_r = 1`, `w_addr_o_r = 2`, `w_dat_o_r = 0x1234`. In cycle N+2, `w_en_o_r = 0`.
- **Load hazard:**
  - Issue a load to R5, then check `chk_src2 = 5`. Required: `stall_o_w = 1`.
  - Return 0x8001 to R5 with the ALU idle. Required: in the cycle `w_en_o_r = 1` with addr 5 and data 0x8001, `stall_o_w = 0`.
- **Priority:** hold `alu_vld` high continuously and push two load returns (R1 = 0x0011, R4 = 0x0044).
  - Once the FIFO is full: `alu_rdy_o_w = 0` and `ld_rdy_o_w = 0`, and the next write is R1.
  - After that: the ALU regains the port while one entry remains.
- **Simultaneous push/pop:** count 1 and the FIFO granted while a new return arrives. Required: count stays 1, and entries are written in arrival order.
- **Scoreboard edges:**
  - Same-cycle issue and retire on R7 with `pend[7] = 1`: stays at 1.
  - Four issues to R0 with no returns: holds at 3.
  - Then three retires to R0: `stall` deasserts after the third.

Source files
------------

// File: rtl/regs_wb_sched.sv
// rtl/regs_wb_sched.sv - register-file writeback arbiter with 2-entry load FIFO and load scoreboard
module regs_wb_sched (
    input  logic        clk_i_w,
    input  logic        rst_i_w,
    input  logic        alu_vld_i_w,
    input  logic [2:0]  alu_addr_i_w,
    input  logic [15:0] alu_dat_i_w,
    output logic        alu_rdy_o_w,
    input  logic        ld_iss_i_w,
    input  logic [2:0]  ld_iss_dst_i_w,
    input  logic        ld_vld_i_w,
    input  logic [2:0]  ld_addr_i_w,
    input  logic [15:0] ld_dat_i_w,
    output logic        ld_rdy_o_w,
    input  logic        chk_vld_i_w,
    input  logic [2:0]  chk_src1_i_w,
    input  logic [2:0]  chk_src2_i_w,
    input  logic [2:0]  chk_dst_i_w,
    output logic        stall_o_w,
    output logic        w_en_o_r,
    output logic [2:0]  w_addr_o_r,
    output logic [15:0] w_dat_o_r
);

    // Slot 0 is always the FIFO head; a pop shifts slot 1 down.
    logic [1:0][2:0]  fa_q, fa_d;
    logic [1:0][15:0] fd_q, fd_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [7:0][1:0]  pend_q, pend_d;
    logic             w_en_q, w_en_d;
    logic [2:0]       w_addr_q, w_addr_d;
    logic [15:0]      w_dat_q, w_dat_d;

    logic       full, gnt_fifo, gnt_alu, push, inc, dec;
    logic [1:0] tail;

    always_comb begin
        full     = (cnt_q == 2'd2);
        gnt_fifo = full || (!alu_vld_i_w && (cnt_q != 2'd0));
        gnt_alu  = !full && alu_vld_i_w;
        push     = ld_vld_i_w && !full;

        ld_rdy_o_w  = !full;
        alu_rdy_o_w = gnt_alu;
        stall_o_w   = chk_vld_i_w && ((pend_q[chk_src1_i_w] != 2'd0) ||
                                      (pend_q[chk_src2_i_w] != 2'd0) ||
                                      (pend_q[chk_dst_i_w]  != 2'd0));

        fa_d     = fa_q;
        fd_d     = fd_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        w_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        w_dat_d  = w_dat_q;
        tail     = cnt_q;
        inc      = 1'b0;
        dec      = 1'b0;

        if (gnt_fifo) begin
            fa_d[0] = fa_q[1];
            fd_d[0] = fd_q[1];
            cnt_d   = cnt_q - 2'd1;
            tail    = cnt_q - 2'd1;
        end
        if (push) begin
            fa_d[tail[0]] = ld_addr_i_w;
            fd_d[tail[0]] = ld_dat_i_w;
            cnt_d         = cnt_d + 2'd1;
        end

        if (gnt_fifo) begin
            w_en_d   = 1'b1;
            w_addr_d = fa_q[0];
            w_dat_d  = fd_q[0];
        end else if (gnt_alu) begin
            w_en_d   = 1'b1;
            w_addr_d = alu_addr_i_w;
            w_dat_d  = alu_dat_i_w;
        end

        // Saturating counters: over-issue or spurious retire must not wrap.
        for (int r = 0; r < 8; r++) begin
            inc = ld_iss_i_w && (ld_iss_dst_i_w == 3'(r));
            dec = gnt_fifo && (fa_q[0] == 3'(r));
            if (inc && !dec && (pend_q[r] != 2'd3)) begin
                pend_d[r] = pend_q[r] + 2'd1;
            end else if (dec && !inc && (pend_q[r] != 2'd0)) begin
                pend_d[r] = pend_q[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i_w or negedge rst_i_w) begin
        if (!rst_i_w) begin
            fa_q     <= '0;
            fd_q     <= '0;
            cnt_q    <= 2'd0;
            pend_q   <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= 3'd0;
            w_dat_q  <= 16'd0;
        end else begin
            fa_q     <= fa_d;
            fd_q     <= fd_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_dat_q  <= w_dat_d;
        end
    end

    assign w_en_o_r   = w_en_q;
    assign w_addr_o_r = w_addr_q;
    assign w_dat_o_r  = w_dat_q;

endmodule

// File: tb/tb_regs_wb_sched.sv
// tb/tb_regs_wb_sched.sv - self-checking bench for regs_wb_sched
module tb_regs_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_vld, ld_iss, ld_vld, chk_vld;
    logic [2:0]  alu_addr, iss_dst, ld_addr, s1, s2, dd;
    logic [15:0] alu_dat, ld_dat;
    logic        alu_rdy, ld_rdy, stall, w_en;
    logic [2:0]  w_addr;
    logic [15:0] w_dat;

    always #5 clk = ~clk;

    regs_wb_sched dut (
        .clk_i_w(clk), .rst_i_w(rst_n),
        .alu_vld_i_w(alu_vld), .alu_addr_i_w(alu_addr), .alu_dat_i_w(alu_dat), .alu_rdy_o_w(alu_rdy),
        .ld_iss_i_w(ld_iss), .ld_iss_dst_i_w(iss_dst),
        .ld_vld_i_w(ld_vld), .ld_addr_i_w(ld_addr), .ld_dat_i_w(ld_dat), .ld_rdy_o_w(ld_rdy),
        .chk_vld_i_w(chk_vld), .chk_src1_i_w(s1), .chk_src2_i_w(s2), .chk_dst_i_w(dd),
        .stall_o_w(stall), .w_en_o_r(w_en), .w_addr_o_r(w_addr), .w_dat_o_r(w_dat)
    );

    // mode 0: model only, 1: also table expectations, 2: also expected stall
    typedef struct {
        int av, aa, ad, li, idst, lv, la, ldat, cv, c1, c2, cd;
        int mode, e_ar, e_lr, e_st, e_en, e_addr, e_dat;
    } vec_t;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } ent_t;

    int          total = 0;
    int          bad = 0;
    ent_t        mq[$];
    int          mpend[8];
    logic        m_en;
    logic [2:0]  m_addr;
    logic [15:0] m_dat;
    vec_t        tbl[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) mpend[i] = 0;
        m_en = 1'b0;
        m_addr = 3'd0;
        m_dat = 16'd0;
    endtask

    // Applies the grant/FIFO/scoreboard rules for one rising edge.
    task automatic model_edge();
        bit   full, gf;
        ent_t h;
        int   v;
        full = (mq.size() == 2);
        gf = full || (!alu_vld && mq.size() > 0);
        h = '{3'd0, 16'd0};
        if (gf) begin
            h = mq.pop_front();
            m_en = 1'b1; m_addr = h.a; m_dat = h.d;
        end else if (alu_vld) begin
            m_en = 1'b1; m_addr = alu_addr; m_dat = alu_dat;
        end else begin
            m_en = 1'b0;
        end
        for (int r = 0; r < 8; r++) begin
            v = mpend[r] + ((ld_iss && iss_dst == 3'(r)) ? 1 : 0) - ((gf && h.a == 3'(r)) ? 1 : 0);
            mpend[r] = (v < 0) ? 0 : (v > 3) ? 3 : v;
        end
        if (ld_vld && !full) mq.push_back('{ld_addr, ld_dat});
    endtask

    task automatic model_compare();
        bit ms;
        ms = chk_vld && (mpend[s1] != 0 || mpend[s2] != 0 || mpend[dd] != 0);
        check("m_alu_rdy", {31'd0, alu_rdy}, {31'd0, alu_vld && mq.size() != 2});
        check("m_ld_rdy", {31'd0, ld_rdy}, {31'd0, mq.size() != 2});
        check("m_stall", {31'd0, stall}, {31'd0, ms});
        check("m_w_en", {31'd0, w_en}, {31'd0, m_en});
        check("m_w_addr", {29'd0, w_addr}, {29'd0, m_addr});
        check("m_w_dat", {16'd0, w_dat}, {16'd0, m_dat});
    endtask

    task automatic drive(input vec_t v);
        alu_vld = v.av[0]; alu_addr = 3'(v.aa); alu_dat = 16'(v.ad);
        ld_iss = v.li[0]; iss_dst = 3'(v.idst);
        ld_vld = v.lv[0]; ld_addr = 3'(v.la); ld_dat = 16'(v.ldat);
        chk_vld = v.cv[0]; s1 = 3'(v.c1); s2 = 3'(v.c2); dd = 3'(v.cd);
    endtask

    task automatic step(input vec_t v, input string nm);
        drive(v);
        @(negedge clk);
        model_compare();
        if (v.mode == 1) begin
            check({nm, "_alu_rdy"}, {31'd0, alu_rdy}, 32'(v.e_ar));
            check({nm, "_ld_rdy"}, {31'd0, ld_rdy}, 32'(v.e_lr));
            check({nm, "_stall"}, {31'd0, stall}, 32'(v.e_st));
            check({nm, "_w_en"}, {31'd0, w_en}, 32'(v.e_en));
            check({nm, "_w_addr"}, {29'd0, w_addr}, 32'(v.e_addr));
            check({nm, "_w_dat"}, {16'd0, w_dat}, 32'(v.e_dat));
        end else if (v.mode == 2) begin
            check({nm, "_stall"}, {31'd0, stall}, 32'(v.e_st));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic vec_t mk(int av, int aa, int ad, int li, int idst, int lv, int la, int ldat,
                                int cv, int c1, int c2, int cd, int mode, int est);
        vec_t v;
        v = '{av, aa, ad, li, idst, lv, la, ldat, cv, c1, c2, cd, mode, 0, 0, est, 0, 0, 0};
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_w_en", {31'd0, w_en}, 32'd0);
        check("rst_w_addr", {29'd0, w_addr}, 32'd0);
        check("rst_w_dat", {16'd0, w_dat}, 32'd0);
        check("rst_ld_rdy", {31'd0, ld_rdy}, 32'd1);
        check("rst_alu_rdy", {31'd0, alu_rdy}, 32'd0);
        rst_n = 1'b1;

        // ALU path, load hazard, priority under continuous ALU, push+pop at count 1
        tbl[0]  = '{1, 2, 'h1234, 0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0,      0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 1, 0, 1, 2, 'h1234};
        tbl[2]  = '{0, 0, 0,      0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 1, 0, 0, 2, 'h1234};
        tbl[3]  = '{0, 0, 0,      1, 5, 0, 0, 0,       1, 5, 0, 0, 1, 0, 1, 0, 0, 2, 'h1234};
        tbl[4]  = '{0, 0, 0,      0, 0, 1, 5, 'h8001,  1, 0, 5, 0, 1, 0, 1, 1, 0, 2, 'h1234};
        tbl[5]  = '{0, 0, 0,      0, 0, 0, 0, 0,       1, 0, 5, 0, 1, 0, 1, 1, 0, 2, 'h1234};
        tbl[6]  = '{0, 0, 0,      0, 0, 0, 0, 0,       1, 0, 5, 0, 1, 0, 1, 0, 1, 5, 'h8001};
        tbl[7]  = '{1, 3, 'h0003, 0, 0, 1, 1, 'h0011,  0, 0, 0, 0, 1, 1, 1, 0, 0, 5, 'h8001};
        tbl[8]  = '{1, 3, 'h0033, 0, 0, 1, 4, 'h0044,  0, 0, 0, 0, 1, 1, 1, 0, 1, 3, 'h0003};
        tbl[9]  = '{1, 6, 'h0066, 0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 0, 0, 1, 3, 'h0033};
        tbl[10] = '{1, 6, 'h0066, 0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 'h0011};
        tbl[11] = '{1, 7, 'h0077, 0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 1, 1, 0, 1, 6, 'h0066};
        tbl[12] = '{0, 0, 0,      0, 0, 1, 2, 'h0222,  0, 0, 0, 0, 1, 0, 1, 0, 1, 7, 'h0077};
        tbl[13] = '{0, 0, 0,      0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 1, 0, 1, 4, 'h0044};
        tbl[14] = '{0, 0, 0,      0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 1, 0, 1, 2, 'h0222};
        tbl[15] = '{0, 0, 0,      0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 1, 0, 0, 2, 'h0222};
        for (int i = 0; i < 16; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // R7: issue and retire in the same cycle with pend[7]=1
        step(mk(0, 0, 0, 1, 7, 1, 7, 'h0777, 0, 0, 0, 0, 0, 0), "r7a");
        step(mk(0, 0, 0, 1, 7, 0, 0, 0,      1, 0, 0, 7, 2, 1), "r7b");
        step(mk(0, 0, 0, 0, 0, 1, 7, 'h0778, 1, 0, 0, 7, 2, 1), "r7c");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 0, 7, 2, 1), "r7d");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 0, 7, 2, 0), "r7e");

        // R0: four issues saturate at 3, three retires clear it
        for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "r0iss");
        step(mk(0, 0, 0, 0, 0, 1, 0, 'h0a00, 1, 0, 1, 1, 2, 1), "r0a");
        step(mk(0, 0, 0, 0, 0, 1, 0, 'h0a01, 1, 0, 1, 1, 2, 1), "r0b");
        step(mk(0, 0, 0, 0, 0, 1, 0, 'h0a02, 1, 0, 1, 1, 2, 1), "r0c");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 1, 1, 2, 1), "r0d");
        step(mk(0, 0, 0, 0, 0, 0, 0, 0,      1, 0, 1, 1, 2, 0), "r0e");

        // Reset mid-stream with FIFO full, pend[3]=2 and a write in flight
        step(mk(1, 1, 'h0101, 1, 3, 0, 0, 0,      0, 0, 0, 0, 0, 0), "mr0");
        step(mk(1, 1, 'h0102, 1, 3, 1, 3, 'h0300, 0, 0, 0, 0, 0, 0), "mr1");
        step(mk(1, 1, 'h0103, 0, 0, 1, 3, 'h0301, 0, 0, 0, 0, 0, 0), "mr2");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0));
        #1;
        check("pre_rst_ld_rdy", {31'd0, ld_rdy}, 32'd0);
        check("pre_rst_stall", {31'd0, stall}, 32'd1);
        check("pre_rst_w_en", {31'd0, w_en}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_w_en", {31'd0, w_en}, 32'd0);
        check("mid_rst_w_addr", {29'd0, w_addr}, 32'd0);
        check("mid_rst_w_dat", {16'd0, w_dat}, 32'd0);
        check("mid_rst_ld_rdy", {31'd0, ld_rdy}, 32'd1);
        check("mid_rst_alu_rdy", {31'd0, alu_rdy}, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 3, 2, 0), "post_rst");

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            step(mk(($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 65535),
                    ($urandom_range(0, 9) < 3) ? 1 : 0, $urandom_range(0, 7),
                    ($urandom_range(0, 9) < 4) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 65535),
                    ($urandom_range(0, 9) < 7) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), 0, 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
